// File: rtl/alu_muldiv.sv
// Registered integer ALU with iterative unsigned multiply/divide and valid/ready handshakes.
// Single-cycle ops answer one cycle after acceptance; MUL/MULHU/DIVU/REMU take WIDTH steps.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] port_out,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    localparam logic [3:0] OpAdd   = 4'd0;
    localparam logic [3:0] OpSub   = 4'd1;
    localparam logic [3:0] OpSll   = 4'd2;
    localparam logic [3:0] OpSrl   = 4'd3;
    localparam logic [3:0] OpSra   = 4'd4;
    localparam logic [3:0] OpAnd   = 4'd5;
    localparam logic [3:0] OpOr    = 4'd6;
    localparam logic [3:0] OpXor   = 4'd7;
    localparam logic [3:0] OpSlt   = 4'd8;
    localparam logic [3:0] OpSltu  = 4'd9;
    localparam logic [3:0] OpMul   = 4'd10;
    localparam logic [3:0] OpMulhu = 4'd11;
    localparam logic [3:0] OpDivu  = 4'd12;
    localparam logic [3:0] OpRemu  = 4'd13;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opd_q, hi_q, lo_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] res_q;
    logic             neg_q, zero_q, ovf_q;

    logic             accept, is_multi, is_mul_q, last_step;
    logic [WIDTH-1:0] sum_ab, diff_ab, alu_res, step_hi, step_lo, multi_res;
    logic [SHW-1:0]   shamt;
    logic             alu_ovf;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    assign accept    = in_valid && in_ready;
    assign is_multi  = (op >= OpMul) && (op <= OpRemu);
    assign is_mul_q  = (op_q == OpMul) || (op_q == OpMulhu);
    assign last_step = (cnt_q == SHW'(WIDTH - 1));
    assign sum_ab    = port_a + port_b;
    assign diff_ab   = port_a - port_b;
    assign shamt     = port_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OpAdd: begin
                alu_res = sum_ab;
                alu_ovf = (port_a[WIDTH-1] == port_b[WIDTH-1]) &&
                          (sum_ab[WIDTH-1] != port_a[WIDTH-1]);
            end
            OpSub: begin
                alu_res = diff_ab;
                alu_ovf = (port_a[WIDTH-1] != port_b[WIDTH-1]) &&
                          (diff_ab[WIDTH-1] != port_a[WIDTH-1]);
            end
            OpSll:   alu_res = port_a << shamt;
            OpSrl:   alu_res = port_a >> shamt;
            OpSra:   alu_res = $signed(port_a) >>> shamt;
            OpAnd:   alu_res = port_a & port_b;
            OpOr:    alu_res = port_a | port_b;
            OpXor:   alu_res = port_a ^ port_b;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(port_a) < $signed(port_b)};
            OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, port_a < port_b};
            default: alu_res = '0;
        endcase
    end

    // Multiply: {hi,lo} shifts right, lo starts as multiplier. Divide: lo holds dividend/quotient,
    // hi the partial remainder; a zero divisor naturally yields quotient all-ones, remainder a.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opd_q};
        div_diff  = div_shift[WIDTH-1:0] - opd_q;
        if (is_mul_q) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end
        case (op_q)
            OpMul, OpDivu: multi_res = step_lo;
            default:       multi_res = step_hi;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept)                         state_d = is_multi ? StCalc : StDone;
                else if (state_q == StDone && out_ready) state_d = StIdle;
            end
            StCalc:  if (last_step) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StCalc: busy = 1'b1;
            StDone: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q   <= '0;
            opd_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            op_q  <= op;
            cnt_q <= '0;
            if (is_multi) begin
                hi_q  <= '0;
                opd_q <= (op == OpMul || op == OpMulhu) ? port_a : port_b;
                lo_q  <= (op == OpMul || op == OpMulhu) ? port_b : port_a;
            end else begin
                res_q  <= alu_res;
                neg_q  <= alu_res[WIDTH-1];
                zero_q <= (alu_res == '0);
                ovf_q  <= alu_ovf;
            end
        end else if (state_q == StCalc) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + SHW'(1);
            if (last_step) begin
                res_q  <= multi_res;
                neg_q  <= multi_res[WIDTH-1];
                zero_q <= (multi_res == '0);
                ovf_q  <= 1'b0;
            end
        end
    end

    assign port_out = res_q;
    assign negative = neg_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vector table, handshake sequences,
// and randomized ops against an arithmetic reference model.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] port_a = '0;
    logic [W-1:0] port_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] port_out;
    logic         negative, zero, overflow, busy;

    int checks = 0;
    int failures = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .port_a(port_a), .port_b(port_b), .out_valid(out_valid), .out_ready(out_ready),
        .port_out(port_out), .negative(negative), .zero(zero), .overflow(overflow), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op from IDLE/DONE, then wait (bounded) for the result.
    task automatic do_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic n, output logic z,
                         output logic v, output int lat);
        @(negedge CLK);
        op = o; port_a = a; port_b = b; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        op = 4'($urandom); port_a = $urandom; port_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        res = port_out; n = negative; z = zero; v = overflow;
    endtask

    // Reference: plain arithmetic on wide integers.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic v, output int lat);
        longint          s;
        longint unsigned p;
        logic [63:0]     pv;
        int              sh;
        sh = int'(b % W);
        v = 1'b0;
        lat = (o >= 10 && o <= 13) ? W + 1 : 1;
        p = longint'(a) * longint'(b);
        pv = p;
        case (o)
            0: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            1: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2:  r = a << sh;
            3:  r = a >> sh;
            4:  r = $signed(a) >>> sh;
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            9:  r = (a < b) ? 1 : 0;
            10: r = pv[31:0];
            11: r = pv[63:32];
            12: r = (b == 0) ? '1 : a / b;
            13: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
    endfunction

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        logic         ovf;
        int           lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    initial begin
        logic [W-1:0] r, er;
        logic         n, z, v, ev;
        int           lat, elat, bcnt;

        vecs[0]  = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1};
        vecs[1]  = '{4'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1};
        vecs[2]  = '{4'd7,  32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 1};
        vecs[3]  = '{4'd4,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1};
        vecs[4]  = '{4'd2,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1};
        vecs[5]  = '{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
        vecs[6]  = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
        vecs[7]  = '{4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33};
        vecs[8]  = '{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33};
        vecs[9]  = '{4'd12, 32'd100,       32'd7,         32'd14,        1'b0, 33};
        vecs[10] = '{4'd13, 32'd100,       32'd7,         32'd2,         1'b0, 33};
        vecs[11] = '{4'd12, 32'h0000_DEAD, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 33};
        vecs[12] = '{4'd13, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b0, 33};
        vecs[13] = '{4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 1};
        vecs[14] = '{4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1};
        vecs[15] = '{4'd3,  32'h8000_0000, 32'h0000_003F, 32'h0000_0001, 1'b0, 1};
        vecs[16] = '{4'd5,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1};
        vecs[17] = '{4'd6,  32'hFF00_0000, 32'h0000_00FF, 32'hFF00_00FF, 1'b0, 1};

        // Reset state
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready",  32'(in_ready), 1);
        check("rst_busy",      32'(busy), 0);
        check("rst_port_out",  port_out, 0);
        check("rst_flags",     {29'd0, negative, zero, overflow}, 0);
        RST = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, n, z, v, lat);
            check($sformatf("vec%0d_out", i), r, vecs[i].exp);
            check($sformatf("vec%0d_neg", i), 32'(n), 32'(vecs[i].exp[W-1]));
            check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].exp == 0));
            check($sformatf("vec%0d_ovf", i), 32'(v), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Back-to-back issue, then backpressure
        @(negedge CLK);
        op = 4'd1; port_a = 5; port_b = 5; in_valid = 1'b1;
        @(posedge CLK); #1;
        check("b2b_sub_valid", 32'(out_valid), 1);
        check("b2b_sub_out",   port_out, 0);
        check("b2b_sub_zero",  32'(zero), 1);
        check("b2b_in_ready",  32'(in_ready), 1);
        op = 4'd7; port_a = 32'hF0F0; port_b = 32'h0F0F;
        @(posedge CLK); #1;
        check("b2b_xor_out",   port_out, 32'hFFFF);
        check("b2b_xor_zero",  32'(zero), 0);
        out_ready = 1'b0;
        op = 4'd0; port_a = 1; port_b = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            check($sformatf("hold%0d_out", k), port_out, 32'hFFFF);
            check($sformatf("hold%0d_valid", k), 32'(out_valid), 1);
            check($sformatf("hold%0d_in_ready", k), 32'(in_ready), 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge CLK); #1;
        check("drain_valid", 32'(out_valid), 0);
        check("drain_keep",  port_out, 32'hFFFF);

        // busy lasts exactly WIDTH cycles for an iterative op
        @(negedge CLK);
        op = 4'd10; port_a = 32'hFFFF_FFFF; port_b = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) bcnt++;
            @(posedge CLK); #1;
        end
        check("busy_cycles", 32'(bcnt), 32);

        // Reset mid-CALC abandons the divide
        @(negedge CLK);
        op = 4'd12; port_a = 100; port_b = 7; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        check("midrst_busy_before", 32'(busy), 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("midrst_valid",    32'(out_valid), 0);
        check("midrst_busy",     32'(busy), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_out",      port_out, 0);
        do_op(4'd0, 2, 3, r, n, z, v, lat);
        check("post_rst_add", r, 5);
        check("post_rst_lat", 32'(lat), 1);

        // Randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            logic [3:0]   o;
            logic [W-1:0] a, b;
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
            model(o, a, b, er, ev, elat);
            do_op(o, a, b, r, n, z, v, lat);
            check($sformatf("rnd%0d_op%0d_out", i, o), r, er);
            check($sformatf("rnd%0d_op%0d_flags", i, o), {29'd0, n, z, v},
                  {29'd0, er[W-1], (er == 0), ev});
            check($sformatf("rnd%0d_op%0d_lat", i, o), 32'(lat), 32'(elat));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, registered successor to the single-cycle combinational ALU.
- Adds iterative unsigned multiply, divide and remainder to the existing integer ops.
- Uses a valid/ready handshake on both input and output.
- Sits in the execute stage. The core stalls on in_ready/out_valid while a multi-cycle op is in flight.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request this cycle.
- op  input  4  operation code (encoding below).
- port_a  input  WIDTH  operand A.
- port_b  input  WIDTH  operand B.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- port_out  output  WIDTH  result.
- negative  output  1  port_out[WIDTH-1].
- zero  output  1  port_out == 0.
- overflow  output  1  signed overflow, ADD/SUB only.
- busy  output  1  iterative op in progress (state CALC).

Behaviour:
- One clock domain (CLK). Reset is synchronous, active-high (RST).
- Reset sets: state IDLE, out_valid 0, port_out 0, negative 0, zero 0, overflow 0, busy 0, in_ready 1.
- RST asserted mid-operation abandons the op; no result is produced.
- Op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 XOR, 8 SLT, 9 SLTU.
  - 10 MUL (low WIDTH bits of product), 11 MULHU (high WIDTH bits, unsigned).
  - 12 DIVU, 13 REMU.
  - 14 and 15 reserved: result 0, all flags computed from 0, so zero=1.
- Shifts use port_b[SHW-1:0] only; upper bits are ignored. SRA is sign-filling.
- Result rules:
  - SLT/SLTU produce 0 or 1, zero-extended.
  - ADD overflow = (a.msb==b.msb) && (out.msb!=a.msb).
  - SUB overflow = (a.msb!=b.msb) && (out.msb!=a.msb).
  - overflow = 0 for every other op.
- Divide-by-zero: DIVU → all ones; REMU → port_a. No error flag.
- Acceptance: a request is accepted when in_valid && in_ready. Operands and op are captured at acceptance; later input changes have no effect.
- FSM:
  - IDLE: in_ready=1.
    - Accepted single-cycle op (0–9, 14, 15) → DONE; result registered at that edge.
    - Accepted op 10–13 → CALC; count=0, operands latched.
  - CALC: busy=1, in_ready=0. One radix-2 step per cycle (shift-add multiply, restoring divide).
    - After WIDTH steps → DONE; result and flags registered.
    - out_ready is ignored in CALC.
  - DONE: out_valid=1; port_out and flags are stable until accepted.
    - in_ready = out_ready (back-to-back issue).
    - out_ready && in_valid → accept the new request with the same transitions as IDLE.
    - out_ready && !in_valid → IDLE, out_valid=0.
    - !out_ready → hold; no request is accepted.
- Latency, from the acceptance edge to out_valid:
  - 1 cycle for single-cycle ops.
  - WIDTH+1 cycles for ops 10–13 (WIDTH steps plus the result register edge).
- Throughput: one single-cycle op per cycle while out_ready=1.
- Flags are registered together with port_out; they are never combinational from the inputs.
- Outputs are undefined-free: port_out and flags keep their last value after the result is consumed, and are qualified by out_valid only.

Test Plan:
- Reset and ADD: assert RST for 2 cycles, then ADD 0x7FFFFFFF + 1 with out_ready=1 → out_valid the next cycle; port_out=0x80000000, overflow=1, negative=1, zero=0.
- Back-to-back and backpressure: SUB 5−5, then XOR 0xF0F0^0x0F0F on consecutive cycles with out_ready=1 → results 0 (zero=1), then 0xFFFF, one per cycle. Drop out_ready for 3 cycles → 0xFFFF held, in_ready=0.
- MUL/MULHU: MUL 0xFFFFFFFF×0xFFFFFFFF → after 33 cycles port_out=0x00000001. MULHU with the same operands → 0xFFFFFFFE. busy=1 for exactly 32 cycles.
- DIVU/REMU: DIVU 100/7 → 14, REMU 100/7 → 2. DIVU x/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234.
- Shifts and compares: SRA 0x80000000 by b=0x21 (uses 1) → 0xC0000000. SLL 1 by 31 → 0x80000000. SLT −1<1 → 1; SLTU 0xFFFFFFFF<1 → 0.
- Reset mid-CALC: start DIVU, assert RST on cycle 10 → next cycle state IDLE, out_valid=0, busy=0, in_ready=1; the following ADD 2+3 returns 5 with latency 1.
